cdc_xfer_scheduler: RTL and testbench

- Fast-domain scheduler that shares one 12-bit fast-to-slow crossing channel among NUM_REQ requesters.
- Uses round-robin arbitration to pick a requester.
- Detects slow-clock edges through a synchronizer.
- Presents each word on xfer_data, holding it stable across exactly one slow capture edge, then acknowledges the requester.
- Sits between the sample producers (fast clock) and the crossing register stage that feeds the slow-domain output register.

---
 rtl/cdc_xfer_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/cdc_xfer_scheduler.sv | 171 +++++++++++++++++
 tb/tb_cdc_xfer_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_xfer_pkg.sv
// Shared types and defaults for the fast-to-slow word crossing scheduler.
package cdc_xfer_pkg;

  localparam int DEF_DATA_W  = 12;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    LOADED    = 2'd2
  } state_e;

  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SRC_W = src_width(DEF_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above ptr_i, wrapping.
module rr_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int SEL_W  = src_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [SEL_W-1:0]   winner_o,
  output logic               found_o
);

  logic             hit;
  logic [SEL_W-1:0] pick;
  int               idx;

  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!hit && req_i[idx]) begin
        hit  = 1'b1;
        pick = SEL_W'(idx);
      end
    end
  end

  assign winner_o = pick;
  assign found_o  = hit;

endmodule

// File: rtl/cdc_xfer_scheduler.sv
// Shares one held-word crossing channel among NUM_REQ fast-domain requesters,
// loading one word per detected slow-clock edge with round-robin fairness.
module cdc_xfer_scheduler
  import cdc_xfer_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int SEL_W      = src_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      slow_clk,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      abort,
  output logic [DATA_W-1:0]         xfer_data,
  output logic                      xfer_valid,
  output logic [SEL_W-1:0]          xfer_src,
  output logic                      busy,
  output logic                      slow_lost
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_last_q;
  logic                   slow_edge;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   slow_lost_q;

  state_e                 state_q;
  logic [SEL_W-1:0]       ptr_q;
  logic [SEL_W-1:0]       xfer_src_q;
  logic [DATA_W-1:0]      xfer_data_q;
  logic                   xfer_valid_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic                   abort_q;
  logic                   busy_q;

  logic [NUM_REQ-1:0]     ack_mask;
  logic [NUM_REQ-1:0]     arb_req;
  logic [SEL_W-1:0]       winner;
  logic                   found;
  logic [DATA_W-1:0]      win_word;

  assign slow_edge = sync_q[SYNC_STAGES-1] & ~sync_last_q;

  always_comb begin
    if (slow_edge)
      cnt_d = '0;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      sync_last_q <= 1'b0;
      cnt_q       <= '0;
      slow_lost_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      sync_last_q <= sync_q[SYNC_STAGES-1];
      cnt_q       <= cnt_d;
      slow_lost_q <= (cnt_d == CNT_MAX);
    end
  end

  // The word being acked is excluded, so a requester still holding req in
  // its ack cycle is not reloaded in the same slot.
  always_comb begin
    ack_mask = '0;
    if (state_q == LOADED)
      ack_mask[xfer_src_q] = 1'b1;
  end

  assign arb_req = req & ~ack_mask;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i    (arb_req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == SEL_W'(i))
        win_word = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= SEL_W'(NUM_REQ - 1);
      xfer_src_q   <= '0;
      xfer_data_q  <= '0;
      xfer_valid_q <= 1'b0;
      ack_q        <= '0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ack_q   <= '0;
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req && !slow_lost_q) begin
            state_q <= WAIT_SLOT;
            busy_q  <= 1'b1;
          end
        end
        WAIT_SLOT: begin
          if (slow_edge) begin
            if (found) begin
              xfer_data_q  <= win_word;
              xfer_src_q   <= winner;
              xfer_valid_q <= 1'b1;
              ptr_q        <= winner;
              state_q      <= LOADED;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        LOADED: begin
          // A real edge takes precedence over a timeout seen in the same cycle.
          if (slow_edge) begin
            ack_q <= ack_mask;
            if (found) begin
              xfer_data_q <= win_word;
              xfer_src_q  <= winner;
              ptr_q       <= winner;
            end else begin
              xfer_valid_q <= 1'b0;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
            end
          end else if (slow_lost_q) begin
            abort_q      <= 1'b1;
            xfer_valid_q <= 1'b0;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          xfer_valid_q <= 1'b0;
          state_q      <= IDLE;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign abort      = abort_q;
  assign xfer_data  = xfer_data_q;
  assign xfer_valid = xfer_valid_q;
  assign xfer_src   = xfer_src_q;
  assign busy       = busy_q;
  assign slow_lost  = slow_lost_q;

endmodule

// File: tb/tb_cdc_xfer_scheduler.sv
// Bench for cdc_xfer_scheduler: directed slot table, corner sequences, and
// random slots against a per-slow-edge transaction model.
module tb_cdc_xfer_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        slow_clk;
  logic [3:0]  req;
  logic [47:0] req_data;
  logic [3:0]  ack;
  logic        abort;
  logic [11:0] xfer_data;
  logic        xfer_valid;
  logic [1:0]  xfer_src;
  logic        busy;
  logic        slow_lost;

  always #5 clk = ~clk;

  cdc_xfer_scheduler #(
    .DATA_W(12), .NUM_REQ(4), .SYNC_STAGES(2), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .reset(reset), .slow_clk(slow_clk), .req(req), .req_data(req_data),
    .ack(ack), .abort(abort), .xfer_data(xfer_data), .xfer_valid(xfer_valid),
    .xfer_src(xfer_src), .busy(busy), .slow_lost(slow_lost)
  );

  int         checks = 0;
  int         errors = 0;
  int         ack_pulses = 0;
  int         abort_pulses = 0;
  int         inv_err = 0;
  logic [3:0] ack_last = 4'b0;
  int         a_snap = 0;
  int         b_snap = 0;

  always @(negedge clk) begin
    if (ack != 4'b0) begin
      ack_pulses++;
      ack_last = ack;
      if ($countones(ack) != 1) inv_err++;
    end
    if (abort) begin
      abort_pulses++;
      if (ack != 4'b0) inv_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One slow period of 10 clk: inputs change while slow_clk is low, the
  // rising edge follows 5 clk later, outputs are sampled 4 clk after it.
  task automatic run_slot(input logic [3:0] r, input logic [47:0] d);
    @(negedge clk);
    slow_clk = 1'b0;
    req      = r;
    req_data = d;
    repeat (5) @(negedge clk);
    slow_clk = 1'b1;
    a_snap   = ack_pulses;
    b_snap   = abort_pulses;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_ack(input string name, input logic [3:0] exp);
    if (exp == 4'b0) begin
      chk({name, ".ack_cnt"}, 32'(ack_pulses - a_snap), 32'd0);
    end else begin
      chk({name, ".ack_cnt"}, 32'(ack_pulses - a_snap), 32'd1);
      chk({name, ".ack"}, 32'(ack_last), 32'(exp));
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".ack"},        32'(ack),        32'd0);
    chk({name, ".abort"},      32'(abort),      32'd0);
    chk({name, ".xfer_data"},  32'(xfer_data),  32'd0);
    chk({name, ".xfer_valid"}, 32'(xfer_valid), 32'd0);
    chk({name, ".xfer_src"},   32'(xfer_src),   32'd0);
    chk({name, ".busy"},       32'(busy),       32'd0);
    chk({name, ".slow_lost"},  32'(slow_lost),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    slow_clk = 1'b0;
    req      = 4'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  r;
    logic [47:0] d;
    logic        v;
    logic [1:0]  src;
    logic [11:0] xd;
    logic [3:0]  ack;
    logic        busy;
  } vec_t;

  vec_t tbl[13];

  // Transaction model: one decision per slow edge.
  int          m_ptr;
  bit          m_loaded;
  int          m_src;
  logic [11:0] m_data;

  initial begin
    int          n;
    logic [3:0]  r;
    logic [47:0] d;
    logic [3:0]  e_ack;
    logic [3:0]  cand;
    int          w;
    int          a0;
    int          b0;

    tbl[0]  = '{4'b1111, 48'h103_102_101_100, 1'b1, 2'd0, 12'h100, 4'b0000, 1'b1};
    tbl[1]  = '{4'b1111, 48'h103_102_101_100, 1'b1, 2'd1, 12'h101, 4'b0001, 1'b1};
    tbl[2]  = '{4'b1111, 48'h103_102_101_100, 1'b1, 2'd2, 12'h102, 4'b0010, 1'b1};
    tbl[3]  = '{4'b1111, 48'h103_102_101_100, 1'b1, 2'd3, 12'h103, 4'b0100, 1'b1};
    tbl[4]  = '{4'b1111, 48'h103_102_101_100, 1'b1, 2'd0, 12'h100, 4'b1000, 1'b1};
    tbl[5]  = '{4'b0000, 48'h0,               1'b0, 2'd0, 12'h000, 4'b0001, 1'b0};
    tbl[6]  = '{4'b0001, 48'h000_000_000_ABC, 1'b1, 2'd0, 12'hABC, 4'b0000, 1'b1};
    tbl[7]  = '{4'b0000, 48'h0,               1'b0, 2'd0, 12'h000, 4'b0001, 1'b0};
    tbl[8]  = '{4'b0100, 48'h000_222_000_000, 1'b1, 2'd2, 12'h222, 4'b0000, 1'b1};
    tbl[9]  = '{4'b0000, 48'h0,               1'b0, 2'd0, 12'h000, 4'b0100, 1'b0};
    tbl[10] = '{4'b0101, 48'h000_5A2_000_5A0, 1'b1, 2'd0, 12'h5A0, 4'b0000, 1'b1};
    tbl[11] = '{4'b0101, 48'h000_5A2_000_5A0, 1'b1, 2'd2, 12'h5A2, 4'b0001, 1'b1};
    tbl[12] = '{4'b0000, 48'h0,               1'b0, 2'd0, 12'h000, 4'b0100, 1'b0};

    reset    = 1'b1;
    slow_clk = 1'b0;
    req      = 4'b0;
    req_data = 48'h0;
    #1;
    chk_all_zero("in_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("after_reset");

    // Contention, single request, fairness after pointer move.
    for (int i = 0; i < 13; i++) begin
      run_slot(tbl[i].r, tbl[i].d);
      chk($sformatf("t%0d.valid", i), 32'(xfer_valid), 32'(tbl[i].v));
      chk($sformatf("t%0d.busy", i),  32'(busy),       32'(tbl[i].busy));
      chk_ack($sformatf("t%0d", i), tbl[i].ack);
      if (tbl[i].v) begin
        chk($sformatf("t%0d.src", i),  32'(xfer_src),  32'(tbl[i].src));
        chk($sformatf("t%0d.data", i), 32'(xfer_data), 32'(tbl[i].xd));
      end
    end

    // Withdrawal before the slot edge.
    @(negedge clk);
    req = 4'b0010;
    repeat (3) @(negedge clk);
    chk("wd.busy_armed", 32'(busy), 32'd1);
    run_slot(4'b0000, 48'h0);
    chk("wd.valid", 32'(xfer_valid), 32'd0);
    chk("wd.busy", 32'(busy), 32'd0);
    chk_ack("wd", 4'b0000);

    // Lost slow clock while a word is loaded.
    run_slot(4'b0010, 48'h000_000_777_000);
    chk("lost.load_src", 32'(xfer_src), 32'd1);
    chk("lost.load_data", 32'(xfer_data), 32'h777);
    slow_clk = 1'b0;
    req      = 4'b0;
    n        = 0;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (slow_lost) begin
        n = k;
        break;
      end
    end
    chk("lost.delay", 32'(n), 32'd1023);
    repeat (5) @(negedge clk);
    chk("lost.abort_cnt", 32'(abort_pulses - b_snap), 32'd1);
    chk("lost.ack_cnt", 32'(ack_pulses - a_snap), 32'd0);
    chk("lost.valid", 32'(xfer_valid), 32'd0);
    chk("lost.busy", 32'(busy), 32'd0);
    chk("lost.flag", 32'(slow_lost), 32'd1);
    req = 4'b0001;
    repeat (20) @(negedge clk);
    chk("lost.blocks_idle", 32'(busy), 32'd0);
    run_slot(4'b0000, 48'h0);
    chk("lost.cleared", 32'(slow_lost), 32'd0);
    chk("lost.idle", 32'(busy), 32'd0);
    run_slot(4'b1010, 48'hDD3_000_DD1_000);
    chk("lost.ptr_src", 32'(xfer_src), 32'd3);
    chk("lost.ptr_data", 32'(xfer_data), 32'hDD3);
    run_slot(4'b0000, 48'h0);
    chk_ack("lost.after", 4'b1000);
    chk("lost.after_valid", 32'(xfer_valid), 32'd0);

    // Asynchronous reset while loaded.
    run_slot(4'b0001, 48'h000_000_000_3C3);
    chk("rst.loaded", 32'(xfer_valid), 32'd1);
    @(negedge clk);
    a0 = ack_pulses;
    b0 = abort_pulses;
    reset = 1'b1;
    #1;
    chk_all_zero("rst.immediate");
    slow_clk = 1'b0;
    req      = 4'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.no_ack", 32'(ack_pulses - a0), 32'd0);
    chk("rst.no_abort", 32'(abort_pulses - b0), 32'd0);
    run_slot(4'b1111, 48'h103_102_101_100);
    chk("rst.first_src", 32'(xfer_src), 32'd0);
    chk("rst.first_data", 32'(xfer_data), 32'h100);
    run_slot(4'b0000, 48'h0);
    chk_ack("rst.ack", 4'b0001);

    // Random slots against the transaction model.
    do_reset();
    m_ptr    = 3;
    m_loaded = 1'b0;
    m_src    = 0;
    m_data   = 12'h0;
    for (int s = 0; s < 60; s++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0;
      d = {16'($urandom), 32'($urandom)};
      e_ack = 4'b0;
      cand  = r;
      if (m_loaded) begin
        e_ack = 4'(1 << m_src);
        cand  = r & ~e_ack;
      end
      w = rr_pick(cand, m_ptr);
      if (w >= 0) begin
        m_loaded = 1'b1;
        m_src    = w;
        m_data   = d[w*12 +: 12];
        m_ptr    = w;
      end else begin
        m_loaded = 1'b0;
      end
      run_slot(r, d);
      chk($sformatf("rnd%0d.valid", s), 32'(xfer_valid), 32'(m_loaded));
      chk($sformatf("rnd%0d.busy", s), 32'(busy), 32'(m_loaded || (r != 4'b0)));
      chk_ack($sformatf("rnd%0d", s), e_ack);
      if (m_loaded) begin
        chk($sformatf("rnd%0d.src", s), 32'(xfer_src), 32'(m_src));
        chk($sformatf("rnd%0d.data", s), 32'(xfer_data), 32'(m_data));
      end
    end

    chk("invariants", 32'(inv_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
